// File: rtl/logic_unit_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_pipe_if
// Description : Handshake and result bundle for the registered logic unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface logic_unit_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_acc;
    logic             in_first;
    logic             clr_cnt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic             red_and;
    logic             red_or;
    logic             red_xor;
    logic             zero;
    logic [CNT_W-1:0] beat_cnt;

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_acc, in_first, clr_cnt, out_ready,
        output in_ready, out_valid, res, red_and, red_or, red_xor, zero, beat_cnt
    );

    modport master (
        output in_valid, in_op, in_a, in_b, in_acc, in_first, clr_cnt, out_ready,
        input  in_ready, out_valid, res, red_and, red_or, red_xor, zero, beat_cnt
    );
endinterface
`default_nettype wire

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_pipe
// Description : One-cycle registered bitwise unit with accumulate mode,
//               reduction flags and a saturating accepted-beat counter.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    logic_unit_pipe_if.slave bus
);

    localparam logic [2:0] c_op_and  = 3'd0;
    localparam logic [2:0] c_op_or   = 3'd1;
    localparam logic [2:0] c_op_not  = 3'd2;
    localparam logic [2:0] c_op_nor  = 3'd3;
    localparam logic [2:0] c_op_nand = 3'd4;
    localparam logic [2:0] c_op_xor  = 3'd5;
    localparam logic [2:0] c_op_xnor = 3'd6;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             r_out_valid;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_acc;
    logic             r_red_and;
    logic             r_red_or;
    logic             r_red_xor;
    logic             r_zero;
    logic [CNT_W-1:0] r_cnt;

    logic             w_in_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] w_f;
    logic [WIDTH-1:0] w_result;

    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;

    // In accumulate mode the running value is the left operand and in_a the right.
    always_comb begin
        w_x = bus.in_acc ? r_acc : bus.in_a;
        w_y = bus.in_acc ? bus.in_a : bus.in_b;
        case (bus.in_op)
            c_op_and:  w_f = w_x & w_y;
            c_op_or:   w_f = w_x | w_y;
            c_op_not:  w_f = ~w_x;
            c_op_nor:  w_f = ~(w_x | w_y);
            c_op_nand: w_f = ~(w_x & w_y);
            c_op_xor:  w_f = w_x ^ w_y;
            c_op_xnor: w_f = ~(w_x ^ w_y);
            default:   w_f = w_x;
        endcase
        w_result = (bus.in_acc && bus.in_first) ? bus.in_a : w_f;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_res       <= '0;
            r_red_and   <= 1'b0;
            r_red_or    <= 1'b0;
            r_red_xor   <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_res       <= w_result;
            r_red_and   <= &w_result;
            r_red_or    <= |w_result;
            r_red_xor   <= ^w_result;
            r_zero      <= ~|w_result;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_accept && bus.in_acc) begin
            r_acc <= w_result;
        end
    end

    // A clear coinciding with an accept counts that beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (bus.clr_cnt) begin
            r_cnt <= w_accept ? c_cnt_one : '0;
        end else if (w_accept && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + c_cnt_one;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.res       = r_res;
    assign bus.red_and   = r_red_and;
    assign bus.red_or    = r_red_or;
    assign bus.red_xor   = r_red_xor;
    assign bus.zero      = r_zero;
    assign bus.beat_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_unit_pipe
// Description : Directed bench for logic_unit_pipe with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_pipe;

    logic clk;
    logic rst_n;

    logic       s_valid;
    logic [2:0] s_op;
    logic [7:0] s_a;
    logic [7:0] s_b;
    logic       s_acc;
    logic       s_first;
    logic       s_clr;
    logic       s_ordy;

    int total = 0;
    int bad   = 0;

    logic_unit_pipe_if #(.WIDTH(8), .CNT_W(16)) if16 ();
    logic_unit_pipe_if #(.WIDTH(8), .CNT_W(2))  if2  ();

    assign if16.in_valid = s_valid;  assign if2.in_valid = s_valid;
    assign if16.in_op    = s_op;     assign if2.in_op    = s_op;
    assign if16.in_a     = s_a;      assign if2.in_a     = s_a;
    assign if16.in_b     = s_b;      assign if2.in_b     = s_b;
    assign if16.in_acc   = s_acc;    assign if2.in_acc   = s_acc;
    assign if16.in_first = s_first;  assign if2.in_first = s_first;
    assign if16.clr_cnt  = s_clr;    assign if2.clr_cnt  = s_clr;
    assign if16.out_ready = s_ordy;  assign if2.out_ready = s_ordy;

    logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
    logic_unit_pipe #(.WIDTH(8), .CNT_W(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(if2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_valid = 0;
    int m_res   = 0;
    int m_acc   = 0;
    int m_cnt16 = 0;
    int m_cnt2  = 0;

    function automatic int fn(input int op, input int x, input int y);
        int r;
        case (op)
            0: r = x & y;
            1: r = x | y;
            2: r = ~x;
            3: r = ~(x | y);
            4: r = ~(x & y);
            5: r = x ^ y;
            6: r = ~(x ^ y);
            default: r = x;
        endcase
        return r & 255;
    endfunction

    function automatic int ones(input int v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += (v >> i) & 1;
        return n;
    endfunction

    function automatic int bump(input int cnt, input int maxv, input bit clr, input bit acc);
        if (clr) return acc ? 1 : 0;
        if (acc) return (cnt + 1 > maxv) ? maxv : cnt + 1;
        return cnt;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0; m_res = 0; m_acc = 0; m_cnt16 = 0; m_cnt2 = 0;
        end else begin
            bit take;
            int r;
            take = s_valid && (m_valid == 0 || s_ordy);
            if (take) begin
                if (!s_acc)       r = fn(s_op, s_a, s_b);
                else if (s_first) r = s_a;
                else              r = fn(s_op, m_acc, s_a);
                if (s_acc) m_acc = r;
                m_res   = r;
                m_valid = 1;
            end else if (s_ordy) begin
                m_valid = 0;
            end
            m_cnt16 = bump(m_cnt16, 65535, s_clr, take);
            m_cnt2  = bump(m_cnt2, 3, s_clr, take);
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        int n;
        n = ones(m_res);
        check("in_ready", int'(if16.in_ready), (m_valid == 0 || s_ordy) ? 1 : 0);
        check("out_valid", int'(if16.out_valid), m_valid);
        check("beat_cnt16", int'(if16.beat_cnt), m_cnt16);
        check("beat_cnt2", int'(if2.beat_cnt), m_cnt2);
        check("out_valid2", int'(if2.out_valid), m_valid);
        if (m_valid != 0) begin
            check("res", int'(if16.res), m_res);
            check("red_and", int'(if16.red_and), (n == 8) ? 1 : 0);
            check("red_or", int'(if16.red_or), (n > 0) ? 1 : 0);
            check("red_xor", int'(if16.red_xor), n % 2);
            check("zero", int'(if16.zero), (m_res == 0) ? 1 : 0);
            check("res2", int'(if2.res), m_res);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int op, input int a, input int b,
                         input bit acc, input bit first);
        s_valid = v; s_op = op[2:0]; s_a = a[7:0]; s_b = b[7:0];
        s_acc = acc; s_first = first;
    endtask

    logic [7:0] sweep_exp [8];
    logic [7:0] chain_in  [3];
    logic [7:0] chain_exp [3];
    int         cnt_exp   [5];

    initial begin
        sweep_exp = '{8'h00, 8'hFF, 8'h3A, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hC5};
        chain_in  = '{8'h0F, 8'hF0, 8'h0F};
        chain_exp = '{8'h0F, 8'hFF, 8'hF0};
        cnt_exp   = '{1, 2, 3, 3, 3};
        drive(0, 0, 0, 0, 0, 0);
        s_clr = 0; s_ordy = 1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", int'(if16.out_valid), 0);
        check("rst_in_ready", int'(if16.in_ready), 1);
        check("rst_res", int'(if16.res), 0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Op sweep, one beat per cycle.
        for (int op = 0; op < 8; op++) begin
            drive(1, op, 8'hC5, 8'h3A, 0, 0);
            step();
            check("sweep_res", int'(if16.res), int'(sweep_exp[op]));
            check("sweep_valid", int'(if16.out_valid), 1);
            if (op == 0) check("sweep_zero", int'(if16.zero), 1);
            if (op == 0) check("sweep_or0", int'(if16.red_or), 0);
            if (op == 5) check("sweep_and5", int'(if16.red_and), 1);
        end
        drive(0, 0, 0, 0, 0, 0);
        step();

        // Backpressure.
        s_clr = 1; step(); s_clr = 0;
        s_ordy = 0;
        drive(1, 1, 8'h12, 8'h40, 0, 0);
        step();
        drive(1, 5, 8'hAA, 8'h0F, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_ready", int'(if16.in_ready), 0);
            check("stall_res", int'(if16.res), 8'h52);
        end
        s_ordy = 1;
        step();
        check("b2b_res", int'(if16.res), 8'hA5);
        check("b2b_cnt", int'(if16.beat_cnt), 2);
        drive(1, 0, 8'hF0, 8'h3C, 0, 0);
        step();
        check("b2b_res2", int'(if16.res), 8'h30);
        drive(0, 0, 0, 0, 0, 0);
        step();
        check("drain_valid", int'(if16.out_valid), 0);

        // XOR accumulate chain, then a fresh chain.
        for (int i = 0; i < 3; i++) begin
            drive(1, 5, int'(chain_in[i]), 8'hFF, 1, (i == 0));
            step();
            check("chain_res", int'(if16.res), int'(chain_exp[i]));
        end
        drive(1, 5, 8'h55, 8'h00, 1, 1);
        step();
        check("chain_new", int'(if16.res), 8'h55);
        drive(1, 1, 8'h0A, 8'h00, 1, 0);
        step();
        check("chain_or", int'(if16.res), 8'h5F);

        // Asynchronous reset during a stall.
        s_ordy = 0;
        drive(1, 7, 8'h9C, 8'h00, 1, 1);
        step();
        drive(0, 0, 0, 0, 0, 0);
        step();
        check("pre_rst_valid", int'(if16.out_valid), 1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", int'(if16.out_valid), 0);
        check("arst_res", int'(if16.res), 0);
        check("arst_cnt", int'(if16.beat_cnt), 0);
        check("arst_ready", int'(if16.in_ready), 1);
        #1 rst_n = 1'b1;
        step();
        check("post_rst_valid", int'(if16.out_valid), 0);
        s_ordy = 1;
        // Accumulator cleared: continuing a chain with OR yields in_a.
        drive(1, 1, 8'h33, 8'h00, 1, 0);
        step();
        check("acc_cleared", int'(if16.res), 8'h33);

        // Saturating counter on the 2-bit instance.
        drive(0, 0, 0, 0, 0, 0);
        s_clr = 1; step(); s_clr = 0;
        check("cnt_clr", int'(if2.beat_cnt), 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, i, 8'hFF, 0, 0);
            step();
            check("cnt_sat", int'(if2.beat_cnt), cnt_exp[i]);
        end
        s_clr = 1;
        step();
        check("cnt_clr_acc", int'(if2.beat_cnt), 1);
        drive(0, 0, 0, 0, 0, 0);
        step();
        check("cnt_clr_only", int'(if2.beat_cnt), 0);
        s_clr = 0;
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Registered, parametrised successor to the two-input gate block: WIDTH-bit operands, opcode-selected bitwise function, one-cycle latency behind a valid/ready handshake.
- Adds an accumulate mode that folds successive input beats through the selected function.
- Adds reduction flags on the result and a saturating beat counter.
- Sits between a stimulus/producer stage and a consumer that may stall.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).
- CNT_W, 16, width of the accepted-beat counter (>=2).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset; asynchronous and active-low.
- in_valid  input  1  input beat present.
- in_ready  output  1  unit can accept a beat this cycle.
- in_op  input  3  function select: 0 AND, 1 OR, 2 NOT, 3 NOR, 4 NAND, 5 XOR, 6 XNOR, 7 PASS.
- in_a  input  WIDTH  first operand.
- in_b  input  WIDTH  second operand; ignored when in_acc=1.
- in_acc  input  1  accumulate mode for this beat.
- in_first  input  1  start of an accumulate chain; meaningful only when in_acc=1.
- clr_cnt  input  1  synchronous clear of beat_cnt.
- out_valid  output  1  result registers hold an unconsumed result.
- out_ready  input  1  consumer accepts the result.
- res  output  WIDTH  registered result.
- red_and  output  1  AND-reduction of res.
- red_or  output  1  OR-reduction of res.
- red_xor  output  1  XOR-reduction (parity) of res.
- zero  output  1  res == 0.
- beat_cnt  output  CNT_W  number of accepted beats, saturating.

Behaviour:
- Reset (rst_n low, asynchronous):
  - res, all flags, out_valid, beat_cnt and the internal accumulator acc_q are cleared to 0.
  - in_ready=1 while out_valid=0, including during reset.
  - Any pending result is dropped; no output beat is produced after reset is released.
- Handshake and latency:
  - in_ready = !out_valid || out_ready (combinational).
  - accept = in_valid && in_ready.
  - On accept: res and the flags load at the next edge and out_valid=1. Latency is 1 cycle.
  - If out_valid && out_ready && !accept, out_valid clears at the next edge.
  - If a result is consumed and a new beat accepted in the same cycle, the new result loads and out_valid stays 1. Full throughput is one beat per cycle.
  - While out_valid=1 and out_ready=0, res and the flags hold stable and no beat is accepted.
- Function f(x,y):
  - AND x&y, OR x|y, NOT ~x, NOR ~(x|y), NAND ~(x&y), XOR x^y, XNOR ~(x^y), PASS x.
  - NOT and PASS ignore y.
- Operand selection:
  - in_acc=0: result = f(in_a, in_b); acc_q is unchanged.
  - in_acc=1, in_first=1: result = in_a; acc_q <= in_a. The opcode is ignored.
  - in_acc=1, in_first=0: result = f(acc_q, in_a); acc_q <= result.
  - acc_q updates only on accept.
- Flags are derived from the computed result and registered together with res, so they always match res.
- beat_cnt:
  - Increments on each accept and saturates at all-ones.
  - clr_cnt=1 without accept: beat_cnt=0 next cycle.
  - clr_cnt=1 with accept in the same cycle: beat_cnt=1.
- Inputs are don't-care when in_valid=0. There is no combinational path from in_* to res or the flags.

Test Plan:
- Exhaustive op sweep, WIDTH=8: in_a=8'hC5, in_b=8'h3A, ops 0..7 with out_ready=1 -> res = 00, FF, 3A, 00, FF, FF, 00, C5. Each result appears exactly 1 cycle after accept, and flags match each res (e.g. op0: zero=1, red_or=0; op5: red_and=1).
- Backpressure: hold out_ready=0 after one accepted beat -> in_ready=0, res stable for 5 cycles. Then assert out_ready together with in_valid -> back-to-back beats with no bubble; beat_cnt=2.
- Accumulate chain, XOR: first beat in_a=8'h0F, then 8'hF0, then 8'h0F -> res = 0F, FF, F0. Start a new chain with in_first=1 and in_a=8'h55 -> res=55.
- Async reset mid-stall: out_valid=1, out_ready=0, then pulse rst_n low between edges -> out_valid, res, beat_cnt and acc_q go to 0 immediately, and in_ready=1.
- Counter: force CNT_W=2, accept 5 beats -> beat_cnt 1, 2, 3, 3, 3. Assert clr_cnt together with an accept -> beat_cnt=1. Assert clr_cnt alone -> beat_cnt=0.
